conv_channel_scheduler: RTL and testbench

CONV_CHANNEL_SCHEDULER -- requirements
Module: conv_channel_scheduler

---
 rtl/conv_sched_pkg.sv | 33 +++
 rtl/chan_idx_counter.sv | 53 +++++
 rtl/conv_channel_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_conv_channel_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// -----------------------------------------------------------------------------
// conv_sched_pkg
// Shared definitions for the convolution channel scheduler:
//   - STATE_W       : width of the scheduler state encoding
//   - CYCLE_CNT_W   : width of the optional busy-cycle performance counter
//   - sched_state_e : scheduler FSM states
//   - sat_inc()     : saturating increment for the performance counter
// -----------------------------------------------------------------------------
package conv_sched_pkg;

   localparam int STATE_W     = 3;
   localparam int CYCLE_CNT_W = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_W = 3'd1,
      ST_RUN    = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } sched_state_e;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [CYCLE_CNT_W-1:0] sat_inc(input logic [CYCLE_CNT_W-1:0] val);
      logic [CYCLE_CNT_W-1:0] res;
      if (val == {CYCLE_CNT_W{1'b1}}) begin
         res = val;
      end else begin
         res = val + CYCLE_CNT_W'(1);
      end
      return res;
   endfunction

endpackage : conv_sched_pkg

// File: rtl/chan_idx_counter.sv
// -----------------------------------------------------------------------------
// chan_idx_counter
// Output-channel index register for the scheduler. Counts from 0 up to
// OUT_CHANNELS-1 and then holds; it never wraps.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : return the index to 0 on the next edge (has priority)
//   inc      : advance the index on the next edge (ignored at the last index)
//   idx      : current channel index (registered)
//   last     : idx equals OUT_CHANNELS-1
// -----------------------------------------------------------------------------
module chan_idx_counter #(
   parameter int OUT_CHANNELS = 8,
   parameter int IDX_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [IDX_W-1:0] idx,
   output logic             last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_CHANNELS - 1);

   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] idx_nx_s;

   // Next index: clear wins, increment saturates at the last channel.
   always_comb begin
      idx_nx_s = idx_r;
      if (clear) begin
         idx_nx_s = {IDX_W{1'b0}};
      end else if (inc && (idx_r != LAST_IDX)) begin
         idx_nx_s = idx_r + IDX_W'(1);
      end else begin
         idx_nx_s = idx_r;
      end
   end

   // Index register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_r <= {IDX_W{1'b0}};
      end else begin
         idx_r <= idx_nx_s;
      end
   end

   assign idx  = idx_r;
   assign last = (idx_r == LAST_IDX);

endmodule : chan_idx_counter

// File: rtl/conv_channel_scheduler.sv
// -----------------------------------------------------------------------------
// conv_channel_scheduler
// Sequences one convolution layer: for every output channel it requests the
// weights, launches the convolution engine and waits for it to finish, then
// emits a single done pulse.
//
// Optional feature: define SCHED_PERF_CNT_EN to add the cycle_cnt output, a
// saturating count of busy cycles for the most recent layer.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start      : layer start request (only honoured while idle)
//   abort      : cancel the layer from any busy state
//   wload_req  : weight-load request for channel chan_idx
//   wload_ack  : weight load finished
//   conv_start : one-cycle launch pulse for the convolution engine
//   conv_done  : convolution of the current channel finished
//   chan_idx   : current output channel
//   busy       : scheduler not idle
//   done       : one-cycle layer-complete pulse
//   cycle_cnt  : busy-cycle counter (SCHED_PERF_CNT_EN only)
//
// Every output comes straight from a flop. The output flops are loaded from
// the next-state decode so they line up with the state register.
// -----------------------------------------------------------------------------
module conv_channel_scheduler
   import conv_sched_pkg::*;
#(
   parameter int OUT_CHANNELS = 8,
   parameter int IDX_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             wload_req,
   input  logic             wload_ack,
   output logic             conv_start,
   input  logic             conv_done,
   output logic [IDX_W-1:0] chan_idx,
   output logic             busy,
   output logic             done
`ifdef SCHED_PERF_CNT_EN
   ,
   output logic [CYCLE_CNT_W-1:0] cycle_cnt
`endif
);

   sched_state_e state_r;
   sched_state_e state_nx_s;

   logic start_acc_s;
   logic cnt_clear_s;
   logic cnt_inc_s;
   logic cnt_last_s;

   logic wload_req_r;
   logic conv_start_r;
   logic busy_r;
   logic done_r;

   // abort also beats a start that arrives while idle.
   assign start_acc_s = (state_r == ST_IDLE) && start && !abort;

   chan_idx_counter #(
      .OUT_CHANNELS (OUT_CHANNELS),
      .IDX_W        (IDX_W)
   ) u_chan_idx (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear_s),
      .inc   (cnt_inc_s),
      .idx   (chan_idx),
      .last  (cnt_last_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode and channel-counter control.
   always_comb begin
      state_nx_s  = state_r;
      cnt_clear_s = 1'b0;
      cnt_inc_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_acc_s) begin
               state_nx_s  = ST_LOAD_W;
               cnt_clear_s = 1'b1;
            end else begin
               state_nx_s  = ST_IDLE;
            end
         end
         ST_LOAD_W: begin
            if (abort) begin
               state_nx_s  = ST_IDLE;
               cnt_clear_s = 1'b1;
            end else if (wload_ack) begin
               state_nx_s  = ST_RUN;
            end else begin
               state_nx_s  = ST_LOAD_W;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nx_s  = ST_IDLE;
               cnt_clear_s = 1'b1;
            end else begin
               state_nx_s  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (abort) begin
               state_nx_s  = ST_IDLE;
               cnt_clear_s = 1'b1;
            end else if (conv_done && cnt_last_s) begin
               // Last channel: index holds so it still names the final channel.
               state_nx_s  = ST_DONE;
            end else if (conv_done) begin
               state_nx_s  = ST_LOAD_W;
               cnt_inc_s   = 1'b1;
            end else begin
               state_nx_s  = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_nx_s  = ST_IDLE;
            cnt_clear_s = 1'b1;
         end
         default: begin
            state_nx_s  = ST_IDLE;
            cnt_clear_s = 1'b1;
         end
      endcase
   end

   // Output flops, decoded from the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wload_req_r  <= 1'b0;
         conv_start_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         wload_req_r  <= (state_nx_s == ST_LOAD_W);
         conv_start_r <= (state_nx_s == ST_RUN);
         busy_r       <= (state_nx_s != ST_IDLE);
         done_r       <= (state_nx_s == ST_DONE);
      end
   end

   assign wload_req  = wload_req_r;
   assign conv_start = conv_start_r;
   assign busy       = busy_r;
   assign done       = done_r;

`ifdef SCHED_PERF_CNT_EN
   logic [CYCLE_CNT_W-1:0] cycle_cnt_r;

   // Busy-cycle counter: cleared by an accepted start, held while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt_r <= {CYCLE_CNT_W{1'b0}};
      end else if (start_acc_s) begin
         cycle_cnt_r <= {CYCLE_CNT_W{1'b0}};
      end else if (state_r != ST_IDLE) begin
         cycle_cnt_r <= sat_inc(cycle_cnt_r);
      end else begin
         cycle_cnt_r <= cycle_cnt_r;
      end
   end

   assign cycle_cnt = cycle_cnt_r;
`endif

endmodule : conv_channel_scheduler

// File: tb/tb_conv_channel_scheduler.sv
// -----------------------------------------------------------------------------
// tb_conv_channel_scheduler
// Two schedulers share the clock: index 0 has 8 channels, index 1 has one.
// Expected channel indices are queued when a layer is started and popped by
// a monitor at every conv_start pulse.
// -----------------------------------------------------------------------------
module tb_conv_channel_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] start_v, abort_v, ack_v, cdone_v;
   logic [1:0] wreq_v, cstart_v, busy_v, done_v;
   logic [3:0] chan0, chan1;
`ifdef SCHED_PERF_CNT_EN
   logic [15:0] cyc0, cyc1;
`endif

   int vectors     = 0;
   int miscompares = 0;
   int exp_q0[$];
   int exp_q1[$];
   int done_cnt[2];
   int cstart_cnt[2];
   int mon_e0, mon_e1;

   conv_channel_scheduler #(.OUT_CHANNELS(8), .IDX_W(4)) dut (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
      .wload_req(wreq_v[0]), .wload_ack(ack_v[0]), .conv_start(cstart_v[0]),
      .conv_done(cdone_v[0]), .chan_idx(chan0), .busy(busy_v[0]), .done(done_v[0])
`ifdef SCHED_PERF_CNT_EN
      , .cycle_cnt(cyc0)
`endif
   );

   conv_channel_scheduler #(.OUT_CHANNELS(1), .IDX_W(4)) dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
      .wload_req(wreq_v[1]), .wload_ack(ack_v[1]), .conv_start(cstart_v[1]),
      .conv_done(cdone_v[1]), .chan_idx(chan1), .busy(busy_v[1]), .done(done_v[1])
`ifdef SCHED_PERF_CNT_EN
      , .cycle_cnt(cyc1)
`endif
   );

   // Scoreboard monitor: every conv_start must carry the next queued channel.
   always @(negedge clk) begin
      if (!rst) begin
         if (cstart_v[0]) begin
            cstart_cnt[0]++;
            vectors++;
            if (exp_q0.size() == 0) begin
               miscompares++;
               $display("FAIL sb0_extra: conv_start at chan %0d, no channel expected", chan0);
            end else begin
               mon_e0 = exp_q0.pop_front();
               if (chan0 !== mon_e0[3:0]) begin
                  miscompares++;
                  $display("FAIL sb0_chan: got %0d want %0d", chan0, mon_e0);
               end
            end
         end
         if (cstart_v[1]) begin
            cstart_cnt[1]++;
            vectors++;
            if (exp_q1.size() == 0) begin
               miscompares++;
               $display("FAIL sb1_extra: conv_start at chan %0d, no channel expected", chan1);
            end else begin
               mon_e1 = exp_q1.pop_front();
               if (chan1 !== mon_e1[3:0]) begin
                  miscompares++;
                  $display("FAIL sb1_chan: got %0d want %0d", chan1, mon_e1);
               end
            end
         end
         if (done_v[0]) done_cnt[0]++;
         if (done_v[1]) done_cnt[1]++;
      end
   end

   // Global time limit.
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [3:0] chan_of(input int d);
      return (d == 0) ? chan0 : chan1;
   endfunction

   // One-cycle input pulse: kind 0 start, 1 wload_ack, 2 conv_done, 3 abort.
   task automatic pulse(input int d, input int kind);
      case (kind)
         0:       start_v[d] = 1'b1;
         1:       ack_v[d]   = 1'b1;
         2:       cdone_v[d] = 1'b1;
         default: abort_v[d] = 1'b1;
      endcase
      @(negedge clk);
      start_v[d] = 1'b0;
      ack_v[d]   = 1'b0;
      cdone_v[d] = 1'b0;
      abort_v[d] = 1'b0;
   endtask

   // Bounded wait: which 0 wload_req, 1 conv_start, 2 done.
   task automatic wait_sig(input int d, input int which, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         case (which)
            0:       ok = wreq_v[d];
            1:       ok = cstart_v[d];
            default: ok = done_v[d];
         endcase
         if (!ok) @(negedge clk);
      end
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: timeout waiting for event %0d on dut %0d", tag, which, d);
      end
   endtask

   // mode: 0 normal, 1 start in WAIT, 2 conv_done in LOAD_W, 3 abort in WAIT, 4 rst in LOAD_W
   task automatic run_channel(input int d, input int ch, input int mode);
      wait_sig(d, 0, "wait_wreq");
      if (mode == 2) begin
         pulse(d, 2);
         vectors++;
         if (wreq_v[d] !== 1'b1 || chan_of(d) !== ch[3:0]) begin
            miscompares++;
            $display("FAIL ign_done: wreq %b chan %0d, want wreq 1 chan %0d", wreq_v[d], chan_of(d), ch);
         end
      end
      if (mode == 4) begin
         #2 rst = 1'b1;
         #1;
         vectors++;
         if ({wreq_v[d], cstart_v[d], busy_v[d], done_v[d], chan_of(d)} !== 8'h00) begin
            miscompares++;
            $display("FAIL async_rst: wreq %b cstart %b busy %b done %b chan %0d, want all 0",
                     wreq_v[d], cstart_v[d], busy_v[d], done_v[d], chan_of(d));
         end
         return;
      end
      repeat (2) @(negedge clk);
      pulse(d, 1);
      wait_sig(d, 1, "wait_cstart");
      if (mode == 3) begin
         @(negedge clk);
         pulse(d, 3);
         vectors++;
         if ({wreq_v[d], cstart_v[d], busy_v[d], done_v[d], chan_of(d)} !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_state: wreq %b cstart %b busy %b done %b chan %0d, want all 0",
                     wreq_v[d], cstart_v[d], busy_v[d], done_v[d], chan_of(d));
         end
         return;
      end
      if (mode == 1) begin
         @(negedge clk);
         pulse(d, 0);
         vectors++;
         if (busy_v[d] !== 1'b1 || wreq_v[d] !== 1'b0 || chan_of(d) !== ch[3:0]) begin
            miscompares++;
            $display("FAIL ign_start: busy %b wreq %b chan %0d, want 1 0 %0d", busy_v[d], wreq_v[d], chan_of(d), ch);
         end
      end
      repeat (5) @(negedge clk);
      pulse(d, 2);
   endtask

   // Runs a layer on dut d; special_ch selects where mode applies.
   task automatic run_layer(input int d, input int n, input int special_ch, input int mode);
      int last_exp;
      int done0;
      int cs0;
      last_exp = (mode == 3) ? special_ch : (mode == 4) ? special_ch - 1 : n - 1;
      for (int i = 0; i <= last_exp; i++) begin
         if (d == 0) exp_q0.push_back(i); else exp_q1.push_back(i);
      end
      done0 = done_cnt[d];
      cs0   = cstart_cnt[d];
      pulse(d, 0);
      for (int ch = 0; ch < n; ch++) begin
         run_channel(d, ch, (ch == special_ch) ? mode : 0);
         if (ch == special_ch && (mode == 3 || mode == 4)) begin
            repeat (3) @(negedge clk);
            vectors++;
            if (done_cnt[d] !== done0) begin
               miscompares++;
               $display("FAIL no_done: got %0d done pulses want 0", done_cnt[d] - done0);
            end
            return;
         end
      end
      wait_sig(d, 2, "wait_done");
      @(negedge clk);
      vectors++;
      if (busy_v[d] !== 1'b0 || chan_of(d) !== 4'd0 || done_v[d] !== 1'b0) begin
         miscompares++;
         $display("FAIL layer_end: busy %b chan %0d done %b, want 0 0 0", busy_v[d], chan_of(d), done_v[d]);
      end
      vectors++;
      if (done_cnt[d] - done0 !== 1 || cstart_cnt[d] - cs0 !== n) begin
         miscompares++;
         $display("FAIL layer_counts: done %0d conv_start %0d, want 1 %0d",
                  done_cnt[d] - done0, cstart_cnt[d] - cs0, n);
      end
      vectors++;
      if ((d == 0 ? exp_q0.size() : exp_q1.size()) !== 0) begin
         miscompares++;
         $display("FAIL sb_leftover: %0d channels never launched", d == 0 ? exp_q0.size() : exp_q1.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_v = 2'b00; abort_v = 2'b00; ack_v = 2'b00; cdone_v = 2'b00;
      repeat (3) @(negedge clk);
      vectors++;
      if ({wreq_v, cstart_v, busy_v, done_v, chan0, chan1} !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset: wreq %b cstart %b busy %b done %b chan %0d/%0d, want all 0",
                  wreq_v, cstart_v, busy_v, done_v, chan0, chan1);
      end
`ifdef SCHED_PERF_CNT_EN
      vectors++;
      if (cyc0 !== 16'h0000 || cyc1 !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_cyc: got %h/%h want 0000", cyc0, cyc1);
      end
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_layer();
      run_layer(0, 8, -1, 0);
   endtask

   task automatic test_abort();
      run_layer(0, 8, 3, 3);
      vectors++;
      if (exp_q0.size() !== 0) begin
         miscompares++;
         $display("FAIL abort_sb: %0d channels left, want 0", exp_q0.size());
      end
      run_layer(0, 8, -1, 0);
   endtask

   task automatic test_ignored_inputs();
      run_layer(0, 8, 2, 1);
      run_layer(0, 8, 4, 2);
   endtask

   task automatic test_reset_mid_layer();
      run_layer(0, 8, 5, 4);
      @(negedge clk);
      rst = 1'b0;
      exp_q0.delete();
      repeat (5) @(negedge clk);
      vectors++;
      if (busy_v[0] !== 1'b0 || wreq_v[0] !== 1'b0 || chan0 !== 4'd0) begin
         miscompares++;
         $display("FAIL rst_idle: busy %b wreq %b chan %0d, want 0 0 0", busy_v[0], wreq_v[0], chan0);
      end
      run_layer(0, 8, -1, 0);
   endtask

   task automatic test_single_channel();
      run_layer(1, 1, -1, 0);
`ifdef SCHED_PERF_CNT_EN
      vectors++;
      if (cyc1 !== 16'd10) begin
         miscompares++;
         $display("FAIL cyc_layer: got %0d want 10", cyc1);
      end
`endif
   endtask

`ifdef SCHED_PERF_CNT_EN
   task automatic test_perf_saturate();
      pulse(1, 0);
      wait_sig(1, 0, "sat_wreq");
      repeat (70000) @(negedge clk);
      vectors++;
      if (cyc1 !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL cyc_sat: got %h want FFFF", cyc1);
      end
      pulse(1, 3);
      vectors++;
      if (busy_v[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_abort: busy %b want 0", busy_v[1]);
      end
   endtask
`endif

   initial begin
      done_cnt[0] = 0; done_cnt[1] = 0;
      cstart_cnt[0] = 0; cstart_cnt[1] = 0;
      test_reset();
      test_full_layer();
      test_abort();
      test_ignored_inputs();
      test_reset_mid_layer();
      test_single_channel();
`ifdef SCHED_PERF_CNT_EN
      test_perf_saturate();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_conv_channel_scheduler
